// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: CP0 exception codes, the canonical
// NOP, and the width of a fetch entry bundle {instr, pc, exc, bd}.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned EXC_CODE_W = 5;

  localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;   // address error on load/fetch

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000; // sll $0,$0,0

  // Bits needed to carry one fetch entry {instr, pc, exc, bd}.
  function automatic int unsigned fd_entry_w(input int unsigned data_w,
                                             input int unsigned exc_w);
    return 2 * data_w + exc_w + 1;
  endfunction

  localparam int unsigned FD_ENTRY_W = fd_entry_w(XLEN, EXC_CODE_W);

endpackage

// File: rtl/fd_queue_core.sv
// Generic Depth x Width synchronous queue with push/pop/clear.
// Head is read combinationally from storage; a push into a full queue is
// legal when it coincides with a pop.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr_i       discard all entries (wins over push/pop)
//   push_i      write wdata_i at the tail
//   pop_i       advance the head
//   wdata_i     entry to write
//   rdata_o     head entry (undefined content when empty)
//   count_o     occupancy
module fd_queue_core #(
  parameter int unsigned Width = 70,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (pop_i && !push_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the owner masks the head while count is zero.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fd_stage_buffer.sv
// IF->ID pipeline buffer: a DEPTH-entry instruction queue between fetch and
// decode with valid/ready handshake, D-stage stall, flush, and exception /
// delay-slot sideband. Misaligned fetches become AdEL entries carrying a NOP.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   f_valid/f_ready                  fetch handshake
//   f_instr/f_pc/f_exc/f_bd          fetched entry
//   d_stall                          decode holds its head entry
//   flush                            discard all queued entries
//   d_valid/d_instr/d_pc/d_exc/d_bd  head entry (empty values when count==0)
//   count                            occupancy
module fd_stage_buffer
  import mips_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 2,
  parameter int unsigned        EXC_W    = 5,
  parameter logic [DATA_W-1:0]  NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [DATA_W-1:0]       f_instr,
  input  logic [DATA_W-1:0]       f_pc,
  input  logic [EXC_W-1:0]        f_exc,
  input  logic                    f_bd,
  input  logic                    d_stall,
  input  logic                    flush,
  output logic                    d_valid,
  output logic [DATA_W-1:0]       d_instr,
  output logic [DATA_W-1:0]       d_pc,
  output logic [EXC_W-1:0]        d_exc,
  output logic                    d_bd,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned EntryW = fd_entry_w(DATA_W, EXC_W);
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;

  logic [CntW-1:0]   count_w;
  logic [EntryW-1:0] wdata, rdata;
  logic              push, pop, adel;
  logic [DATA_W-1:0] wr_instr;
  logic [EXC_W-1:0]  wr_exc;

  assign d_valid = (count_w != '0);
  assign pop     = d_valid & ~d_stall;
  // A full queue still accepts when the head leaves this cycle.
  assign f_ready = (count_w < CntW'(DEPTH)) | pop;
  assign push    = f_valid & f_ready;

  // Misaligned fetch with no earlier exception: tag AdEL, squash the word.
  assign adel     = (f_pc[1:0] != 2'b00) && (f_exc == EXC_W'(EXC_NONE));
  assign wr_exc   = adel ? EXC_W'(EXC_ADEL) : f_exc;
  assign wr_instr = adel ? NOP_WORD : f_instr;
  assign wdata    = {wr_instr, f_pc, wr_exc, f_bd};

  fd_queue_core #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count_w)
  );

  always_comb begin
    d_instr = NOP_WORD;
    d_pc    = '0;
    d_exc   = '0;
    d_bd    = 1'b0;
    if (d_valid) begin
      d_instr = rdata[EntryW-1 -: DATA_W];
      d_pc    = rdata[EXC_W+1 +: DATA_W];
      d_exc   = rdata[1 +: EXC_W];
      d_bd    = rdata[0];
    end
  end

  assign count = count_w;

endmodule

// File: tb/tb_fd_stage_buffer.sv
module tb_fd_stage_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, f_valid, f_bd, d_stall, flush;
  logic [31:0] f_instr, f_pc;
  logic [4:0]  f_exc;
  logic        f_ready, d_valid, d_bd;
  logic [31:0] d_instr, d_pc;
  logic [4:0]  d_exc;
  logic [1:0]  count;

  int n_checks = 0;
  int n_err    = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  fd_stage_buffer #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .EXC_W    (5),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .f_instr (f_instr),
    .f_pc    (f_pc),
    .f_exc   (f_exc),
    .f_bd    (f_bd),
    .d_stall (d_stall),
    .flush   (flush),
    .d_valid (d_valid),
    .d_instr (d_instr),
    .d_pc    (d_pc),
    .d_exc   (d_exc),
    .d_bd    (d_bd),
    .count   (count)
  );

  // Behavioural model: a queue of entries as the decode stage should see them.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;

  ent_t mq[$];

  function automatic logic m_ready();
    return (mq.size() < DEPTH) || (mq.size() > 0 && !d_stall);
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    e.instr = 32'h0; e.pc = 32'h0; e.exc = 5'd0; e.bd = 1'b0;
    if (mq.size() > 0) e = mq[0];
    return e;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit   do_pop, do_push;
    if (reset || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && !d_stall;
      do_push = f_valid && m_ready();
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = f_pc;
        e.bd = f_bd;
        if (f_exc == 5'd0 && f_pc[1:0] != 2'b00) begin
          e.exc   = 5'd4;
          e.instr = 32'h0;
        end else begin
          e.exc   = f_exc;
          e.instr = f_instr;
        end
        mq.push_back(e);
      end
    end
    armed = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    ent_t h;
    if (armed) begin
      h = m_head();
      chk("d_valid", 32'(d_valid), 32'(mq.size() > 0));
      chk("d_instr", d_instr, h.instr);
      chk("d_pc",    d_pc,    h.pc);
      chk("d_exc",   32'(d_exc), 32'(h.exc));
      chk("d_bd",    32'(d_bd),  32'(h.bd));
      chk("count",   32'(count), 32'(mq.size()));
      chk("f_ready", 32'(f_ready), 32'(m_ready()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] exc, input logic bd);
    f_valid = 1'b1;
    f_instr = instr;
    f_pc    = pc;
    f_exc   = exc;
    f_bd    = bd;
  endtask

  initial begin
    reset = 1'b1; f_valid = 1'b0; f_instr = '0; f_pc = '0; f_exc = '0; f_bd = 1'b0;
    d_stall = 1'b0; flush = 1'b0;
    cyc(); cyc();
    chk("rst d_valid", 32'(d_valid), 32'd0);
    chk("rst f_ready", 32'(f_ready), 32'd1);
    chk("rst count",   32'(count),   32'd0);
    chk("rst d_instr", d_instr,      32'h0);
    reset = 1'b0;

    // Single push into an empty queue: visible one cycle later.
    offer(32'h3C01_1234, 32'h0000_3000, 5'd0, 1'b0);
    cyc();
    f_valid = 1'b0;
    chk("t1 d_valid", 32'(d_valid), 32'd1);
    chk("t1 d_instr", d_instr, 32'h3C01_1234);
    chk("t1 d_pc",    d_pc,    32'h0000_3000);
    chk("t1 count",   32'(count), 32'd1);
    chk("t1 model pc", m_head().pc, 32'h0000_3000);
    cyc();
    chk("t1 drained", 32'(count), 32'd0);

    // Stall fills the queue; third offer refused, head held.
    d_stall = 1'b1;
    offer(32'h0000_0001, 32'h0000_3000, 5'd0, 1'b0); cyc();
    offer(32'h0000_0002, 32'h0000_3004, 5'd0, 1'b0); cyc();
    offer(32'h0000_0003, 32'h0000_3008, 5'd0, 1'b0); #1;
    chk("t2 f_ready full", 32'(f_ready), 32'd0);
    chk("t2 count",        32'(count),   32'd2);
    cyc();
    chk("t2 head held", d_pc, 32'h0000_3000);
    chk("t2 count held", 32'(count), 32'd2);

    // Full queue with pop: push accepted in the same cycle.
    d_stall = 1'b0; #1;
    chk("t3 f_ready pop", 32'(f_ready), 32'd1);
    cyc();
    f_valid = 1'b0;
    chk("t3 count", 32'(count), 32'd2);
    chk("t3 head",  d_pc, 32'h0000_3004);
    cyc();
    chk("t3 tail", d_pc, 32'h0000_3008);
    chk("t3 model tail", m_head().pc, 32'h0000_3008);
    cyc();
    chk("t3 empty", 32'(count), 32'd0);

    // Misaligned fetch becomes AdEL; an existing exception code wins.
    d_stall = 1'b1;
    offer(32'h8C22_0010, 32'h0000_3002, 5'd0, 1'b1); cyc();
    offer(32'h2402_0007, 32'h0000_3006, 5'd6, 1'b0);
    chk("t4 adel exc",   32'(d_exc), 32'd4);
    chk("t4 adel instr", d_instr,    32'h0);
    chk("t4 adel pc",    d_pc,       32'h0000_3002);
    chk("t4 adel bd",    32'(d_bd),  32'd1);
    chk("t4 model exc",  32'(m_head().exc), 32'd4);
    cyc();
    f_valid = 1'b0; d_stall = 1'b0;
    cyc();
    chk("t4 exc6",   32'(d_exc), 32'd6);
    chk("t4 instr6", d_instr,    32'h2402_0007);
    chk("t4 pc6",    d_pc,       32'h0000_3006);
    cyc();

    // Flush with a simultaneous push and pop drops everything.
    d_stall = 1'b1;
    offer(32'h1111_0000, 32'h0000_5000, 5'd0, 1'b0); cyc();
    offer(32'h1111_0004, 32'h0000_5004, 5'd0, 1'b0); cyc();
    chk("t5 full", 32'(count), 32'd2);
    offer(32'h1111_0008, 32'h0000_5008, 5'd0, 1'b0);
    d_stall = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; f_valid = 1'b0;
    chk("t5 count",   32'(count),   32'd0);
    chk("t5 d_valid", 32'(d_valid), 32'd0);
    chk("t5 d_instr", d_instr,      32'h0);
    chk("t5 d_pc",    d_pc,         32'h0);
    // Flush while stalled still clears.
    d_stall = 1'b1;
    offer(32'h1111_0010, 32'h0000_5010, 5'd0, 1'b0); cyc();
    f_valid = 1'b0; flush = 1'b1; cyc();
    flush = 1'b0;
    chk("t5 stall flush", 32'(count), 32'd0);

    // Reset mid-operation, then a fresh push.
    offer(32'h2222_0000, 32'h0000_6000, 5'd0, 1'b0); cyc();
    offer(32'h2222_0004, 32'h0000_6004, 5'd0, 1'b1); cyc();
    f_valid = 1'b0; reset = 1'b1; cyc();
    reset = 1'b0;
    chk("t6 count",   32'(count),   32'd0);
    chk("t6 d_valid", 32'(d_valid), 32'd0);
    chk("t6 d_bd",    32'(d_bd),    32'd0);
    chk("t6 f_ready", 32'(f_ready), 32'd1);
    d_stall = 1'b0;
    offer(32'h3333_0000, 32'h0000_4000, 5'd0, 1'b0); cyc();
    f_valid = 1'b0;
    chk("t6 first push", d_pc, 32'h0000_4000);
    cyc();

    // Mixed traffic against the model.
    for (int i = 0; i < 64; i++) begin
      offer(32'hA000_0000 + 32'(i),
            32'h0000_7000 + 32'(i * 4) + ((i % 7 == 3) ? 32'd2 : 32'd0),
            (i % 11 == 5) ? 5'd12 : 5'd0, 1'(i % 2));
      f_valid = (i % 3) != 2;
      d_stall = (i % 5) == 1 || (i % 13) > 9;
      flush   = (i == 40) || (i == 50);
      reset   = (i == 50) || (i == 57);
      cyc();
    end
    f_valid = 1'b0; d_stall = 1'b0; flush = 1'b0; reset = 1'b0;
    cyc(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fd_stage_buffer.md
Name: fd_stage_buffer

Overview:
- Parametrised IF→ID pipeline register for the 5-stage MIPS core.
- Generalises the single-entry D register into a DEPTH-entry instruction queue with a valid/ready handshake, D-stage stall, synchronous flush, and exception/delay-slot sideband.
- Sits between the fetch unit and the D-stage controller; its head entry feeds decode.

Parameters:
- DATA_W, 32, instruction and PC width.
- DEPTH, 2, queue entries; power of two, ≥1.
- EXC_W, 5, exception-code width (CP0 ExcCode).
- NOP_WORD, 32'h0000_0000, instruction presented when the queue is empty.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- f_valid  in  1  fetch offers an entry this cycle.
- f_ready  out  1  buffer accepts the entry this cycle.
- f_instr  in  DATA_W  fetched instruction.
- f_pc  in  DATA_W  PC of the fetched instruction.
- f_exc  in  EXC_W  exception code raised at fetch (0 = none).
- f_bd  in  1  entry is in a branch delay slot.
- d_stall  in  1  D stage holds its current entry (hazard unit).
- flush  in  1  discard all queued entries (exception/eret).
- d_valid  out  1  head entry valid.
- d_instr  out  DATA_W  head instruction.
- d_pc  out  DATA_W  head PC.
- d_exc  out  EXC_W  head exception code.
- d_bd  out  1  head delay-slot flag.
- count  out  $clog2(DEPTH)+1  occupancy, for debug and the perf counter.

Behaviour:
- Clock is clk; reset is synchronous, active-high; all state updates on posedge clk.
- Reset:
  - count=0, read and write pointers = 0.
  - Outputs: d_valid=0, d_instr=NOP_WORD, d_pc=0, d_exc=0, d_bd=0, f_ready=1.
- Definitions:
  - push = f_valid & f_ready.
  - pop = d_valid & ~d_stall.
- f_ready = (count < DEPTH) | pop. It is combinational. Pushing into a full queue in the same cycle as a pop is legal.
- Latency: an entry pushed into an empty queue appears on d_* on the next cycle (1 cycle, same as the old D register). There is no combinational f→d path.
- Outputs are the head entry, read combinationally from storage. When count==0:
  - d_valid=0, d_instr=NOP_WORD, d_pc=0, d_exc=0, d_bd=0.
- Count update:
  - push & ~pop → count+1.
  - pop & ~push → count−1.
  - push & pop → unchanged; the head advances and the new entry is written at the tail.
- Pointers wrap modulo DEPTH.
- Pop while empty cannot occur (d_valid=0). Push while full without a pop cannot occur (f_ready=0).
- d_stall=1 holds the head stable, including all sideband. Pushes still fill free slots.
- Fetch-address check on the write path:
  - Condition: f_pc[1:0]≠0 and f_exc==0.
  - Stored exc = EXC_ADEL (4) and stored instr = NOP_WORD; PC and bd are stored as given.
  - A nonzero f_exc is stored unchanged and takes priority.
- flush:
  - Next cycle: count=0, pointers=0, outputs at their empty values.
  - Flush overrides a simultaneous push and pop; the pushed entry is dropped.
  - flush with d_stall=1 still clears.
- reset overrides flush; both produce the same state.
- Reset asserted mid-operation discards all entries, identically to flush.
- DEPTH=1 must behave exactly like a register with stall and flush. With continuous d_stall=0 it gives full throughput.

Decomposition:
- Package mips_pkg, shared with the controller and CP0:
  - EXC_NONE=0, EXC_ADEL=4, NOP_WORD.
  - Width of the fetch entry bundle: {instr, pc, exc, bd}.
- One sub-module: fd_queue_core. It is a generic DEPTH×W synchronous queue with pointers, count, push/pop/clear.
- fd_stage_buffer wraps fd_queue_core and adds:
  - the handshake logic;
  - the AdEL substitution;
  - the empty-output muxing.

Test Plan:
- Reset, then push {instr=32'h3C01_1234, pc=32'h0000_3000}.
  → Next cycle: d_valid=1, d_instr=32'h3C01_1234, d_pc=32'h3000, count=1.
- DEPTH=2, d_stall=1, push 3 entries (pc 3000/3004/3008).
  → count reaches 2, f_ready=0 on the 3rd offer, head stays pc=3000.
  → Release stall: entries drain in order, 3000→3004.
- Full queue, d_stall=0, f_valid=1 in the same cycle.
  → f_ready=1, count stays 2, head advances to pc=3004, tail = new pc=3008.
- Push pc=32'h0000_3002, f_exc=0.
  → d_exc=4, d_instr=0, d_pc=32'h3002.
  → Repeat with f_exc=6: d_exc=6.
- count=2, flush=1 with f_valid=1 in the same cycle.
  → Next cycle: count=0, d_valid=0, d_instr=0, d_pc=0; the pushed entry is lost.
- Reset asserted while count=2 with d_stall=1.
  → Next cycle: all outputs at reset values, f_ready=1.
  → The first push after reset appears at the head after 1 cycle.
